// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel position, display enable and lock status from raw hsync/vsync.
// Lock needs two consecutive correct periods after a first, unevaluated edge.
module vga_sync_decoder #(
    parameter int H_SYNCPULSE = 96,
    parameter int H_BPORCH    = 48,
    parameter int H_DISPLAY   = 640,
    parameter int H_FPORCH    = 16,
    parameter int H_SYNC      = 800,
    parameter int V_SYNCPULSE = 2,
    parameter int V_BPORCH    = 33,
    parameter int V_DISPLAY   = 480,
    parameter int V_SYNC      = 525
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    output logic [10:0] hpos,
    output logic [9:0]  vpos,
    output logic [9:0]  px_x,
    output logic [8:0]  px_y,
    output logic        de,
    output logic        h_locked,
    output logic        v_locked,
    output logic [10:0] line_len,
    output logic        sync_err
);
    localparam int HA = H_SYNCPULSE + H_BPORCH;
    localparam int HE = HA + H_DISPLAY;
    localparam int VA = V_SYNCPULSE + V_BPORCH;
    localparam int VE = VA + V_DISPLAY;
    logic        h_d, v_d, h_first, v_first;
    logic [1:0]  h_match, v_match;
    logic [10:0] h_cnt;
    logic        h_rise, h_fall, v_rise, h_tmo, h_per_bad, v_per_bad, pw_bad;
    logic [11:0] h_per;
    logic [10:0] v_per, vpos_w;
    always_comb begin
        h_rise    = hsync & ~h_d;
        h_fall    = ~hsync & h_d;
        v_rise    = vsync & ~v_d;
        h_per     = {1'b0, hpos} + 12'd1;
        v_per     = {1'b0, vpos} + 11'd1;
        vpos_w    = {1'b0, vpos};
        h_tmo     = !h_rise && hpos == 11'd2047;
        h_per_bad = h_rise && !h_first && h_per != 12'(H_SYNC);
        v_per_bad = v_rise && !v_first && v_per != 11'(V_SYNC);
        pw_bad    = h_fall && h_cnt != 11'(H_SYNCPULSE);
        h_locked  = h_match == 2'd2;
        v_locked  = v_match == 2'd2 && h_locked;
        de        = h_locked && v_locked && hpos >= 11'(HA) && hpos < 11'(HE)
                    && vpos_w >= 11'(VA) && vpos_w < 11'(VE);
        px_x      = de ? 10'(hpos - 11'(HA)) : 10'd0;
        px_y      = de ? 9'(vpos_w - 11'(VA)) : 9'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            h_d      <= 1'b0;
            v_d      <= 1'b0;
            h_cnt    <= '0;
            hpos     <= '0;
            vpos     <= '0;
            line_len <= '0;
            h_first  <= 1'b1;
            v_first  <= 1'b1;
            h_match  <= '0;
            v_match  <= '0;
            sync_err <= 1'b0;
        end else begin
            h_d      <= hsync;
            v_d      <= vsync;
            h_cnt    <= hsync ? (h_cnt == 11'd2047 ? h_cnt : h_cnt + 11'd1) : 11'd0;
            hpos     <= h_rise ? 11'd0 : (hpos == 11'd2047 ? hpos : hpos + 11'd1);
            if (h_rise)
                line_len <= h_per[11] ? 11'd2047 : h_per[10:0];
            h_first  <= h_rise ? 1'b0 : (h_tmo ? 1'b1 : h_first);
            // a missing hsync drops lock quietly: no period was ever measured
            if (h_rise && !h_first)
                h_match <= h_per_bad ? 2'd0 : (h_match == 2'd2 ? 2'd2 : h_match + 2'd1);
            else if (h_tmo)
                h_match <= 2'd0;
            // vsync rise wins over a coincident hsync rise
            vpos     <= v_rise ? 10'd0 : (h_rise && vpos != 10'd1023 ? vpos + 10'd1 : vpos);
            v_first  <= v_rise ? 1'b0 : v_first;
            if (!h_locked)
                v_match <= 2'd0;
            else if (v_rise && !v_first)
                v_match <= v_per_bad ? 2'd0 : (v_match == 2'd2 ? 2'd2 : v_match + 2'd1);
            sync_err <= pw_bad | h_per_bad | v_per_bad;
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: randomized and directed sync streams checked against a timestamp-based model.
module tb_vga_sync_decoder;
    localparam int HSP = 96, HBP = 48, HD = 640, HFP = 16, HS = 800;
    localparam int VSP = 2, VBP = 3, VD = 12, VS = 20;
    logic        clk = 0, rst = 1, hsync = 0, vsync = 0;
    logic [10:0] hpos, line_len;
    logic [9:0]  vpos, px_x;
    logic [8:0]  px_y;
    logic        de, h_locked, v_locked, sync_err;
    typedef struct packed {
        logic [10:0] hpos;
        logic [9:0]  vpos;
        logic [10:0] line_len;
        logic [9:0]  px_x;
        logic [8:0]  px_y;
        logic        de, hl, vl, err;
    } out_t;
    out_t q[$];
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    vga_sync_decoder #(.H_SYNCPULSE(HSP), .H_BPORCH(HBP), .H_DISPLAY(HD), .H_FPORCH(HFP), .H_SYNC(HS),
                       .V_SYNCPULSE(VSP), .V_BPORCH(VBP), .V_DISPLAY(VD), .V_SYNC(VS)) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .hpos(hpos), .vpos(vpos),
        .px_x(px_x), .px_y(px_y), .de(de), .h_locked(h_locked), .v_locked(v_locked),
        .line_len(line_len), .sync_err(sync_err));
    // model works from edge timestamps and event counts rather than counters
    int cyc = 0, h_base = 0, hs_start = 0, ll = 0, lines = 0, h_good = 0, v_good = 0;
    bit h_first = 1, v_first = 1, ph = 0, pv = 0;
    function automatic int mn(int a, int b);
        return a < b ? a : b;
    endfunction
    task automatic model(input bit r, input bit h, input bit v);
        out_t e;
        int hp;
        bit hr, hf, vr, hl_pre, err;
        cyc++;
        err = 0;
        if (r) begin
            h_base = cyc; lines = 0; ll = 0; h_first = 1; v_first = 1;
            h_good = 0; v_good = 0; ph = 0; pv = 0;
        end else begin
            hp = mn(cyc - 1 - h_base, 2047);
            hr = h && !ph; hf = !h && ph; vr = v && !pv; hl_pre = h_good >= 2;
            if (hf && cyc - hs_start != HSP) err = 1;
            if (hr) begin
                hs_start = cyc;
                ll = mn(cyc - h_base, 2047);
                if (!h_first) begin
                    if (cyc - h_base == HS) h_good++;
                    else begin h_good = 0; err = 1; end
                end
                h_first = 0;
                h_base = cyc;
            end else if (hp == 2047) begin
                h_good = 0; h_first = 1;
            end
            if (vr) begin
                if (!v_first) begin
                    if (lines + 1 == VS) v_good++;
                    else begin v_good = 0; err = 1; end
                end
                v_first = 0;
                lines = 0;
            end else if (hr) lines = mn(lines + 1, 1023);
            if (!hl_pre) v_good = 0;
            ph = h; pv = v;
        end
        hp = mn(cyc - h_base, 2047);
        e.hpos = 11'(hp);
        e.vpos = 10'(lines);
        e.line_len = 11'(ll);
        e.hl = h_good >= 2;
        e.vl = v_good >= 2 && e.hl;
        e.de = e.hl && e.vl && hp >= HSP + HBP && hp < HSP + HBP + HD
               && lines >= VSP + VBP && lines < VSP + VBP + VD;
        e.px_x = e.de ? 10'(hp - HSP - HBP) : 10'd0;
        e.px_y = e.de ? 9'(lines - VSP - VBP) : 9'd0;
        e.err = err;
        q.push_back(e);
    endtask
    task automatic tick(input bit r, input bit h, input bit v);
        rst = r; hsync = h; vsync = v;
        model(r, h, v);
        @(negedge clk);
    endtask
    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask
    task automatic line(input int len, input int pw, input bit vs, input int probe);
        for (int i = 0; i < len; i++) begin
            tick(0, i < pw, vs);
            if (probe == 1 && i == 144) begin
                chk("de@144", de, 1); chk("px_x@144", px_x, 0); chk("px_y@144", px_y, 0);
            end
            if (probe == 1 && i == 783) begin chk("de@783", de, 1); chk("px_x@783", px_x, 639); end
            if (probe == 1 && i == 784) begin chk("de@784", de, 0); chk("px_x@784", px_x, 0); end
            if (probe == 2 && i == 0) begin
                chk("err_799", sync_err, 1); chk("unlock_799", h_locked, 0); chk("len_799", line_len, 799);
            end
            if (probe == 3 && i == 0) chk("relock", h_locked, 1);
            if (probe == 4 && i == 95) chk("pw_err", sync_err, 1);
            if (probe == 4 && i == 96) begin chk("pw_err_end", sync_err, 0); chk("pw_lock", h_locked, 1); end
        end
    endtask
    initial begin
        forever begin
            out_t e, a;
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                a.hpos = hpos; a.vpos = vpos; a.line_len = line_len; a.px_x = px_x; a.px_y = px_y;
                a.de = de; a.hl = h_locked; a.vl = v_locked; a.err = sync_err;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t: got hpos=%0d vpos=%0d len=%0d x=%0d y=%0d de=%b hl=%b vl=%b err=%b expected hpos=%0d vpos=%0d len=%0d x=%0d y=%0d de=%b hl=%b vl=%b err=%b",
                             $time, a.hpos, a.vpos, a.line_len, a.px_x, a.px_y, a.de, a.hl, a.vl, a.err,
                             e.hpos, e.vpos, e.line_len, e.px_x, e.px_y, e.de, e.hl, e.vl, e.err);
                end
            end
        end
    end
    initial begin
        repeat (3) tick(1, 0, 0);
        chk("rst_hpos", hpos, 0); chk("rst_hl", h_locked, 0); chk("rst_err", sync_err, 0);
        for (int f = 0; f < 3; f++)
            for (int l = 0; l < VS; l++) line(HS, HSP, l < VSP, (f == 2 && l == VSP + VBP) ? 1 : 0);
        chk("lock_h", h_locked, 1); chk("lock_v", v_locked, 1); chk("lock_len", line_len, 800);
        line(799, HSP, 0, 0);
        line(HS, HSP, 0, 2);
        line(HS, HSP, 0, 0);
        line(HS, HSP, 0, 3);
        line(HS, 95, 0, 4);
        repeat (2100) tick(0, 0, 0);
        chk("tmo_hpos", hpos, 2047); chk("tmo_hl", h_locked, 0); chk("tmo_vl", v_locked, 0);
        chk("tmo_err", sync_err, 0);
        repeat (3) line(HS, HSP, 0, 0);
        for (int i = 0; i <= 400; i++) tick(0, i < HSP, 0);
        tick(1, 0, 0);
        chk("mrst_hpos", hpos, 0); chk("mrst_hl", h_locked, 0); chk("mrst_len", line_len, 0);
        chk("mrst_de", de, 0);
        line(HS, HSP, 0, 0);
        line(HS, HSP, 0, 0);
        line(HS, HSP, 0, 3);
        for (int n = 0; n < 20; n++) begin
            int len, pw;
            len = $urandom_range(0, 3) == 0 ? int'($urandom_range(790, 810)) : HS;
            pw  = $urandom_range(0, 3) == 0 ? int'($urandom_range(90, 100)) : HSP;
            if ($urandom_range(0, 29) == 0) tick(1, 0, 0);
            line(len, pw, $urandom_range(0, 9) == 0, 0);
        end
        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
